// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds and a sticky
// overflow/underflow error flag. Status flags are registered from the next-state count.
module fifo_umbral #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned BAJO_RST   = 1,
  parameter int unsigned ALTO_RST   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] BajoRst = BAJO_RST[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] AltoRst = ALTO_RST[ADDR_WIDTH-1:0];

  localparam logic [1:0] Vacio   = 2'd0;
  localparam logic [1:0] Parcial = 2'd1;
  localparam logic [1:0] Lleno   = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH-1:0] bajo_q, alto_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, error_q, error_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  pop_acc, push_acc, fault;

  always_comb begin
    pop_acc  = pop & (state_q != Vacio);
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    push_acc = push & ((state_q != Lleno) | pop_acc);
    fault    = (push & (state_q == Lleno) & ~pop) | (pop & (state_q == Vacio));
    count_d  = count_q + (ADDR_WIDTH + 1)'(push_acc) - (ADDR_WIDTH + 1)'(pop_acc);

    if (count_d == '0) begin
      state_d = Vacio;
    end else if (count_d == DepthCnt) begin
      state_d = Lleno;
    end else begin
      state_d = Parcial;
    end

    ae_d = count_d <= {1'b0, bajo_q};
    af_d = (alto_q == '0) ? (count_d == DepthCnt) : (count_d >= {1'b0, alto_q});

    // A fault in the init cycle must survive the clear.
    error_d = fault ? 1'b1 : (init ? 1'b0 : error_q);
  end

  always_ff @(posedge clk) begin
    if (!reset && push_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= Vacio;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      bajo_q   <= BajoRst;
      alto_q   <= AltoRst;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q];
      end
      valid_q <= pop_acc;
      count_q <= count_d;
      state_q <= state_d;
      error_q <= error_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      if (init) begin
        bajo_q <= umbral_bajo;
        alto_q <= umbral_alto;
      end
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign full         = (state_q == Lleno);
  assign empty        = (state_q == Vacio);
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fifo_error   = error_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Bench for fifo_umbral: directed scenarios followed by random traffic, all checked
// against a queue-based reference model.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset, init, push, pop;
  logic [1:0] ub, ua;
  logic [5:0] din, dout;
  logic       vout, full, empty, af, ae, err;
  logic [2:0] cnt;

  int total = 0;
  int bad   = 0;

  logic [5:0] q[$];
  logic [5:0] m_dout;
  bit         m_v, m_err, m_ae, m_af;
  int         m_bajo, m_alto;

  fifo_umbral #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(2),
    .BAJO_RST  (1),
    .ALTO_RST  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_bajo (ub),
    .umbral_alto (ua),
    .push        (push),
    .data_in     (din),
    .pop         (pop),
    .data_out    (dout),
    .valid_out   (vout),
    .full        (full),
    .empty       (empty),
    .almost_full (af),
    .almost_empty(ae),
    .fifo_error  (err),
    .count       (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(cnt), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 4));
    chk("almost_empty", 32'(ae), 32'(m_ae));
    chk("almost_full", 32'(af), 32'(m_af));
    chk("fifo_error", 32'(err), 32'(m_err));
    chk("valid_out", 32'(vout), 32'(m_v));
    chk("data_out", 32'(dout), 32'(m_dout));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check outputs.
  task automatic step(input bit r, input bit in, input bit pu, input logic [5:0] d,
                      input bit po, input int b, input int a);
    int n;
    bit pa, wa;
    reset = r; init = in; push = pu; din = d; pop = po; ub = b[1:0]; ua = a[1:0];
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = '0; m_v = 0; m_err = 0; m_ae = 1; m_af = 0; m_bajo = 1; m_alto = 3;
    end else begin
      n  = q.size();
      pa = po && (n > 0);
      wa = pu && ((n < 4) || pa);
      if ((po && n == 0) || (pu && n == 4 && !po)) m_err = 1;
      else if (in) m_err = 0;
      m_v = pa;
      if (pa) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      n    = q.size();
      m_ae = (n <= m_bajo);
      m_af = (m_alto == 0) ? (n == 4) : (n >= m_alto);
      if (in) begin
        m_bajo = b;
        m_alto = a;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; init = 0; push = 0; pop = 0; din = '0; ub = '0; ua = '0;

    // Reset and idle
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_data", 32'(dout), 32'd0);

    // Thresholds then fill
    step(0, 1, 0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 6'(8'h0A + i), 0, 0, 0);
    chk("t2_full", 32'(full), 32'd1);

    // Overflow, then drain in order
    step(0, 0, 1, 6'h15, 0, 0, 0);
    chk("t3_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk("t3_data", 32'(dout), 32'h0A + 32'(i));
      chk("t3_valid", 32'(vout), 32'd1);
    end

    // Simultaneous push/pop at full, mid, empty
    step(0, 1, 0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 6'(i + 1), 0, 0, 0);
    step(0, 0, 1, 6'h20, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 6'h21, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 6'h22, 1, 0, 0);
    chk("t4_count", 32'(cnt), 32'd1);
    chk("t4_err", 32'(err), 32'd1);

    // Init clears error; fault during init keeps it set
    step(0, 1, 0, 0, 0, 2, 0);
    chk("t5_clr", 32'(err), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 3);
    chk("t5_set", 32'(err), 32'd1);

    // Pointer wrap then reset mid-transfer
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'(6'h30 + i), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 6'(6'h38 + i), 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t6_count", 32'(cnt), 32'd0);

    // Random traffic
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 5), ($urandom_range(99) < 60),
           6'($urandom), ($urandom_range(99) < 50), int'($urandom_range(3)),
           int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
